div32_seq: RTL

Sequential 32-bit restoring divider that inverts the work of the 32-bit carry-lookahead adder datapath: it computes quotient and remainder by one trial subtraction per cycle through a 32-bit subtractor built from the existing `cla4` slices. It sits beside the adder in the arithmetic unit and talks to its producer and consumer over valid/ready handshakes on both sides.

---
 rtl/div_pkg.sv | 31 +++
 rtl/cla4.sv | 36 +++
 rtl/sub32.sv | 40 ++++
 rtl/div32_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and constants for the sequential 32-bit divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [WIDTH-1:0] ONE_W      = 32'd1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = 6'd31;
    localparam logic [CNT_W-1:0] CNT_ONE    = 6'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when n is set; used for magnitude and sign fix-up.
    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? (~v + ONE_W) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla4.sv
// ============================================================================
// Module   : cla4
// Purpose  : 4-bit carry-lookahead adder slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];

endmodule

`default_nettype wire

// File: rtl/sub32.sv
// ============================================================================
// Module   : sub32
// Purpose  : 32-bit subtractor a - b from eight chained cla4 slices
//            (b inverted, carry-in 1); carry-out high means no borrow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sub32
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             no_borrow_o
);

    logic [WIDTH-1:0] b_n;
    logic [8:0]       c;

    assign b_n  = ~b_i;
    assign c[0] = 1'b1;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_slice
            cla4 u_cla4 (
                .a_i (a_i[4*i +: 4]),
                .b_i (b_n[4*i +: 4]),
                .c_i (c[i]),
                .s_o (diff_o[4*i +: 4]),
                .c_o (c[i+1])
            );
        end
    endgenerate

    assign no_borrow_o = c[8];

endmodule

`default_nettype wire

// File: rtl/div32_seq.sv
// ============================================================================
// Module   : div32_seq
// Purpose  : Sequential 32-bit restoring divider with valid/ready handshakes.
//            Define DIV_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_seq
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q, rmd_q;
    logic             dbz_q;

    logic [WIDTH-1:0] rem_shift, diff, q_raw, r_raw, q_fix, r_fix;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic             no_borrow, q_bit, accept, dsr_zero;

    assign accept    = (state_q == IDLE) && in_valid;
    assign dsr_zero  = (divisor == '0);
    assign rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};

    sub32 u_sub32 (
        .a_i         (rem_shift),
        .b_i         (dsr_q),
        .diff_o      (diff),
        .no_borrow_o (no_borrow)
    );

    // A set MSB before the shift means the 33-bit partial remainder already exceeds the divisor.
    assign q_bit = no_borrow | rem_q[WIDTH-1];
    assign q_raw = {dvd_q[WIDTH-2:0], q_bit};
    assign r_raw = q_bit ? diff : rem_shift;

`ifdef DIV_SIGNED_EN
    logic qneg_q, rneg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
        end
    end

    assign dvd_mag = neg_if(dividend[WIDTH-1], dividend);
    assign dsr_mag = neg_if(divisor[WIDTH-1], divisor);
    assign q_fix   = neg_if(qneg_q, q_raw);
    assign r_fix   = neg_if(rneg_q, r_raw);
`else
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
    assign q_fix   = q_raw;
    assign r_fix   = r_raw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = dsr_zero ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            rem_q <= '0;
            dvd_q <= dvd_mag;
            dsr_q <= dsr_mag;
            cnt_q <= CNT_LOAD;
            dbz_q <= dsr_zero;
            if (dsr_zero) begin
                quo_q <= DIV_ZERO_Q;
                rmd_q <= dividend;
            end
        end else if (state_q == CALC) begin
            rem_q <= r_raw;
            dvd_q <= q_raw;
            cnt_q <= cnt_q - CNT_ONE;
            // The last iteration's result goes straight to the output registers with sign fix-up.
            if (cnt_q == '0) begin
                quo_q <= q_fix;
                rmd_q <= r_fix;
            end
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
